// File: rtl/uart_tx.sv
// 8N1 serial transmitter: one word per valid/ready accept, start bit on the line the cycle after accept.
// Ready stays low for the whole (DATA_BITS+2)*CLKS_PER_BIT-cycle frame; inputs are ignored while busy.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 bit_end;

  // Wrap of the baud counter marks the last cycle of the current bit.
  assign bit_end = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shreg    <= tx_data;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // Ready rises after the stop bit, which yields the one idle cycle between frames.
          if (bit_end) begin
            baud_cnt <= '0;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: CLKS_PER_BIT=4/DATA_BITS=8 instance plus a CLKS_PER_BIT=2/DATA_BITS=7 instance.
module tb_uart_tx;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, tx_valid, tx_ready, tx, busy;
  logic [7:0] tx_data;
  logic       reset_b, tx_valid_b, tx_ready_b, tx_b, busy_b;
  logic [6:0] tx_data_b;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy)
  );

  uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(7)) dut_b (
    .clock(clock), .reset(reset_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // bit 0 = start bit ... bit 9 = stop bit, in line order
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, " tx"}, 32'(tx), 32'd1);
    chk({nm, " ready"}, 32'(tx_ready), 32'd1);
    chk({nm, " busy"}, 32'(busy), 32'd0);
  endtask

  // Called at a negedge; the following rising edge is the accept edge.
  task automatic start_a(input logic [7:0] d);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: tx_ready never returned to 1");
    end
    tx_data  = d;
    tx_valid = 1'b1;
  endtask

  // Samples the 40 frame cycles t+1..t+40 and decodes the data bits at mid-bit.
  task automatic check_frame(input logic [9:0] f, input string nm, input bit keep_valid,
                             input logic [7:0] next_d, input bit disturb, output logic [7:0] dec);
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 0) begin
        if (keep_valid) tx_data = next_d;
        else tx_valid = 1'b0;
      end
      if (disturb) begin
        if (i == 9) tx_data = 8'h3C;
        tx_valid = (i == 12 || i == 20);
      end
      chk($sformatf("%s tx c%0d", nm, i + 1), 32'(tx), 32'(f[i / 4]));
      chk($sformatf("%s ready c%0d", nm, i + 1), 32'(tx_ready), 32'd0);
      chk($sformatf("%s busy c%0d", nm, i + 1), 32'(busy), 32'd1);
      if (i % 4 == 2 && i >= 6 && i <= 34) d[(i - 6) / 4] = tx;
    end
    dec = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [5];
    logic [7:0] dec;
    logic [6:0] dec_b;
    logic [8:0] fb;
    int         len;

    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h00, 10'h200};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h01, 10'h202};
    vecs[4] = '{8'h80, 10'h300};

    reset = 1'b1; tx_valid = 1'b0; tx_data = '0;
    reset_b = 1'b1; tx_valid_b = 1'b0; tx_data_b = '0;
    repeat (2) @(negedge clock);
    // Valid during the last reset edge must not start a frame.
    tx_valid = 1'b1; tx_data = 8'hFF; tx_valid_b = 1'b1;
    @(negedge clock);
    idle_chk("reset");
    chk("reset_b tx", 32'(tx_b), 32'd1);
    chk("reset_b ready", 32'(tx_ready_b), 32'd1);
    reset = 1'b0; tx_valid = 1'b0; reset_b = 1'b0; tx_valid_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      idle_chk($sformatf("post_reset c%0d", i));
    end

    foreach (vecs[k]) begin
      @(negedge clock);
      start_a(vecs[k].data);
      check_frame(vecs[k].frame, $sformatf("vec%0d", k), 1'b0, 8'h00, 1'b0, dec);
      chk($sformatf("vec%0d decoded", k), 32'(dec), 32'(vecs[k].data));
      @(negedge clock);
      idle_chk($sformatf("vec%0d t+41", k));
      @(negedge clock);
      idle_chk($sformatf("vec%0d t+42", k));
    end

    // Back-to-back with valid held: second start bit at t+42.
    @(negedge clock);
    start_a(8'h00);
    check_frame(10'h200, "b2b0", 1'b1, 8'hFF, 1'b0, dec);
    chk("b2b0 decoded", 32'(dec), 32'h00);
    @(negedge clock);
    idle_chk("b2b gap");
    check_frame(10'h3FE, "b2b1", 1'b0, 8'h00, 1'b0, dec);
    chk("b2b1 decoded", 32'(dec), 32'hFF);
    @(negedge clock);
    idle_chk("b2b end");

    // Data change and valid pulses while busy are ignored.
    @(negedge clock);
    start_a(8'hC3);
    check_frame(10'h386, "hold", 1'b0, 8'h00, 1'b1, dec);
    chk("hold decoded", 32'(dec), 32'hC3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      idle_chk($sformatf("hold idle c%0d", i));
    end

    // Reset mid-DATA aborts the frame; a fresh accept afterwards is clean.
    @(negedge clock);
    start_a(8'h00);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      if (i == 1) tx_valid = 1'b0;
    end
    chk("abort tx t+15", 32'(tx), 32'd0);
    chk("abort ready t+15", 32'(tx_ready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    idle_chk("abort t+16");
    reset = 1'b0;
    @(negedge clock);
    idle_chk("abort t+17");
    start_a(8'h55);
    check_frame(10'h2AA, "after_abort", 1'b0, 8'h00, 1'b0, dec);
    chk("after_abort decoded", 32'(dec), 32'h55);
    @(negedge clock);
    idle_chk("after_abort end");

    // CLKS_PER_BIT=2, DATA_BITS=7: 18-cycle frame.
    fb = 9'h182;
    len = 0;
    dec_b = '0;
    @(negedge clock);
    tx_data_b = 7'h41;
    tx_valid_b = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      if (i == 0) tx_valid_b = 1'b0;
      chk($sformatf("b tx c%0d", i + 1), 32'(tx_b), 32'(fb[i / 2]));
      if (busy_b) len++;
      if (i % 2 == 1 && i >= 3 && i <= 15) dec_b[(i - 3) / 2] = tx_b;
    end
    @(negedge clock);
    chk("b ready t+19", 32'(tx_ready_b), 32'd1);
    chk("b busy t+19", 32'(busy_b), 32'd0);
    chk("b frame length", 32'(len), 32'd18);
    chk("b decoded", 32'(dec_b), 32'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
